pll_clken_bank: RTL and testbench

PLL_CLKEN_BANK -- requirements
Module: pll_clken_bank

---
 rtl/pll_clken_pkg.sv | 12 +
 rtl/clken_div_ch.sv | 48 ++++
 rtl/pll_clken_bank.sv | 143 ++++++++++++++
 tb/tb_pll_clken_bank.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pll_clken_pkg.sv
// rtl/pll_clken_pkg.sv - shared state encoding and synchroniser depth for the PLL clock-enable bank
package pll_clken_pkg;

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    COUNT     = 2'd1,
    RUN       = 2'd2
  } state_t;

  localparam int SYNC_DEPTH = 2;

endpackage

// File: rtl/clken_div_ch.sv
// rtl/clken_div_ch.sv - one clock-enable channel: active/pending divisor and phase counter
module clken_div_ch #(
  parameter int DIV_W       = 16,
  parameter int DEFAULT_DIV = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic             resync,
  input  logic             we,
  input  logic [DIV_W-1:0] wdata,
  output logic             en
);

  logic [DIV_W-1:0] r_act;
  logic [DIV_W-1:0] r_pend;
  logic [DIV_W-1:0] r_phase;
  logic             w_short;
  logic             w_wrap;
  logic             w_load;
  logic [DIV_W-1:0] w_next_div;

  // Divisors 0 and 1 mean "every cycle", so every cycle is also a period boundary.
  assign w_short    = (r_act < DIV_W'(2));
  assign w_wrap     = run && (w_short || (r_phase == (r_act - DIV_W'(1))));
  assign w_load     = !run || resync || w_wrap;
  assign w_next_div = we ? wdata : r_pend;
  assign en         = w_wrap;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_act   <= DIV_W'(DEFAULT_DIV);
      r_pend  <= DIV_W'(DEFAULT_DIV);
      r_phase <= '0;
    end else begin
      if (we) begin
        r_pend <= wdata;
      end
      if (w_load) begin
        r_act   <= w_next_div;
        r_phase <= '0;
      end else begin
        r_phase <= r_phase + DIV_W'(1);
      end
    end
  end

endmodule

// File: rtl/pll_clken_bank.sv
// rtl/pll_clken_bank.sv - PLL lock qualifier with downstream reset and a bank of divided clock enables
module pll_clken_bank
  import pll_clken_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int DIV_W       = 16,
  parameter int LOCK_STABLE = 1024,
  parameter int DEFAULT_DIV = 2
) (
  input  logic              clkin,
  input  logic              reset_n,
  input  logic              lock,
  input  logic              cfg_we,
  input  logic [3:0]        cfg_ch,
  input  logic [DIV_W-1:0]  cfg_div,
  input  logic              resync,
  input  logic              clr_lost,
  output logic              rst_out_n,
  output logic              locked,
  output logic              lost_lock,
  output logic [NUM_CH-1:0] clk_en
);

  localparam int CNT_W = $clog2(LOCK_STABLE);

  logic [SYNC_DEPTH-1:0] r_rst_sync;
  logic [SYNC_DEPTH-1:0] r_lock_sync;
  logic                  w_rst_n;
  logic                  w_lock_s;
  state_t                r_state;
  state_t                w_state_nxt;
  logic [CNT_W-1:0]      r_cnt;
  logic [CNT_W-1:0]      w_cnt_nxt;
  logic                  r_rst_out_n;
  logic                  r_locked;
  logic                  r_lost;
  logic                  w_run;
  logic                  w_resync;
  logic                  w_lost_set;

  // Assertion reaches every flop at once; release is retimed to clkin.
  always_ff @(posedge clkin or negedge reset_n) begin
    if (!reset_n) begin
      r_rst_sync <= '0;
    end else begin
      r_rst_sync <= {r_rst_sync[SYNC_DEPTH-2:0], 1'b1};
    end
  end

  assign w_rst_n = r_rst_sync[SYNC_DEPTH-1];

  always_ff @(posedge clkin or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_lock_sync <= '0;
    end else begin
      r_lock_sync <= {r_lock_sync[SYNC_DEPTH-2:0], lock};
    end
  end

  assign w_lock_s = r_lock_sync[SYNC_DEPTH-1];

  always_ff @(posedge clkin or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_state <= WAIT_LOCK;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      WAIT_LOCK: begin
        if (w_lock_s) begin
          w_state_nxt = COUNT;
          w_cnt_nxt   = '0;
        end
      end
      COUNT: begin
        if (!w_lock_s) begin
          w_state_nxt = WAIT_LOCK;
        end else if (r_cnt == CNT_W'(LOCK_STABLE - 1)) begin
          w_state_nxt = RUN;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      RUN: begin
        if (!w_lock_s) begin
          w_state_nxt = WAIT_LOCK;
        end
      end
      default: begin
        w_state_nxt = WAIT_LOCK;
      end
    endcase
  end

  assign w_run      = (r_state == RUN);
  assign w_resync   = w_run && resync;
  assign w_lost_set = w_run && !w_lock_s;

  // Outputs follow the next state so they change on the same edge as the FSM.
  always_ff @(posedge clkin or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_rst_out_n <= 1'b0;
      r_locked    <= 1'b0;
      r_lost      <= 1'b0;
    end else begin
      r_rst_out_n <= (w_state_nxt == RUN);
      r_locked    <= (w_state_nxt == RUN);
      if (w_lost_set) begin
        r_lost <= 1'b1;
      end else if (clr_lost) begin
        r_lost <= 1'b0;
      end
    end
  end

  assign rst_out_n = r_rst_out_n;
  assign locked    = r_locked;
  assign lost_lock = r_lost;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    localparam logic [3:0] CH = 4'(i);
    clken_div_ch #(
      .DIV_W       (DIV_W),
      .DEFAULT_DIV (DEFAULT_DIV)
    ) u_ch (
      .clk    (clkin),
      .rst_n  (w_rst_n),
      .run    (w_run),
      .resync (w_resync),
      .we     (cfg_we && (cfg_ch == CH)),
      .wdata  (cfg_div),
      .en     (clk_en[i])
    );
  end

endmodule

// File: tb/tb_pll_clken_bank.sv
// tb/tb_pll_clken_bank.sv - self-checking bench for pll_clken_bank with a lock-streak / period model
module tb_pll_clken_bank;

  localparam int NCH = 4;
  localparam int DW  = 16;
  localparam int LS  = 16;
  localparam int DD  = 2;

  logic           clkin = 1'b0;
  logic           reset_n = 1'b1;
  logic           lock = 1'b0;
  logic           cfg_we = 1'b0;
  logic [3:0]     cfg_ch = '0;
  logic [DW-1:0]  cfg_div = '0;
  logic           resync = 1'b0;
  logic           clr_lost = 1'b0;
  logic           rst_out_n;
  logic           locked;
  logic           lost_lock;
  logic [NCH-1:0] clk_en;

  int total = 0;
  int bad = 0;

  always #5 clkin = ~clkin;

  pll_clken_bank #(
    .NUM_CH      (NCH),
    .DIV_W       (DW),
    .LOCK_STABLE (LS),
    .DEFAULT_DIV (DD)
  ) dut (
    .clkin     (clkin),
    .reset_n   (reset_n),
    .lock      (lock),
    .cfg_we    (cfg_we),
    .cfg_ch    (cfg_ch),
    .cfg_div   (cfg_div),
    .resync    (resync),
    .clr_lost  (clr_lost),
    .rst_out_n (rst_out_n),
    .locked    (locked),
    .lost_lock (lost_lock),
    .clk_en    (clk_en)
  );

  // Model: release after LS+1 consecutive synchronised-high samples; each channel
  // remembers the cycle its current period started and pulses d-1 cycles later.
  int m_rel;
  bit m_s1, m_s2;
  int m_streak;
  bit m_lost;
  int m_t;
  int m_act[NCH];
  int m_pend[NCH];
  int m_start[NCH];

  function automatic void model_reset();
    m_s1 = 1'b0;
    m_s2 = 1'b0;
    m_streak = 0;
    m_lost = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      m_act[i] = DD;
      m_pend[i] = DD;
      m_start[i] = m_t;
    end
  endfunction

  function automatic bit m_run();
    return m_streak >= LS + 1;
  endfunction

  function automatic bit m_pulse(int i, int c, bit run);
    return run && ((m_act[i] <= 1) || (c - m_start[i] == m_act[i] - 1));
  endfunction

  function automatic void model_edge();
    bit run_pre;
    bit we;
    bit pulse;
    int c;
    run_pre = m_run();
    c = m_t;
    if (!reset_n) begin
      m_rel = 0;
      model_reset();
    end else if (m_rel < 2) begin
      m_rel++;
      model_reset();
    end else begin
      for (int i = 0; i < NCH; i++) begin
        we = cfg_we && (int'(cfg_ch) == i);
        pulse = m_pulse(i, c, run_pre);
        if (!run_pre || resync || pulse) begin
          m_start[i] = c + 1;
          m_act[i] = we ? int'(cfg_div) : m_pend[i];
        end
        if (we) m_pend[i] = int'(cfg_div);
      end
      if (run_pre && !m_s2) m_lost = 1'b1;
      else if (clr_lost) m_lost = 1'b0;
      m_streak = m_s2 ? ((m_streak < LS + 2) ? m_streak + 1 : m_streak) : 0;
      m_s2 = m_s1;
      m_s1 = lock;
    end
    m_t = c + 1;
  endfunction

  task automatic chk(input string name, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (t=%0t)", name, got, want, $time);
    end
  endtask

  task automatic tick();
    @(posedge clkin);
    model_edge();
    #1;
    chk("m_rst_out_n", int'(rst_out_n), int'(m_run()));
    chk("m_locked", int'(locked), int'(m_run()));
    chk("m_lost_lock", int'(lost_lock), int'(m_lost));
    for (int i = 0; i < NCH; i++) begin
      chk($sformatf("m_clk_en%0d", i), int'(clk_en[i]), int'(m_pulse(i, m_t, m_run())));
    end
  endtask

  task automatic cfg_write(input int ch, input int div);
    cfg_we = 1'b1;
    cfg_ch = 4'(ch);
    cfg_div = DW'(div);
    tick();
    cfg_we = 1'b0;
  endtask

  typedef struct {
    int ch;
    int div;
    int first;
    int period;
  } vec_t;

  vec_t tbl[4];

  initial begin
    tbl[0] = '{ch: 0, div: 2, first: 2, period: 2};
    tbl[1] = '{ch: 1, div: 3, first: 3, period: 3};
    tbl[2] = '{ch: 2, div: 4, first: 4, period: 4};
    tbl[3] = '{ch: 3, div: 1, first: 1, period: 1};
    m_t = 0;
    m_rel = 0;
    model_reset();

    #1 reset_n = 1'b0;
    #1;
    chk("rst_async_rst_out_n", int'(rst_out_n), 0);
    chk("rst_async_clk_en", int'(clk_en), 0);
    repeat (3) tick();
    chk("rst_locked", int'(locked), 0);
    chk("rst_lost_lock", int'(lost_lock), 0);
    reset_n = 1'b1;
    repeat (4) tick();

    foreach (tbl[v]) cfg_write(tbl[v].ch, tbl[v].div);
    cfg_write(7, 9);
    repeat (2) tick();

    // Lock rise: release on the 19th edge, nothing before.
    lock = 1'b1;
    for (int e = 1; e <= 18; e++) begin
      tick();
      chk("pre_release_locked", int'(locked), 0);
      chk("pre_release_clk_en", int'(clk_en), 0);
    end
    tick();
    chk("release_locked", int'(locked), 1);
    chk("release_rst_out_n", int'(rst_out_n), 1);
    for (int c = 1; c <= 12; c++) begin
      if (c > 1) tick();
      foreach (tbl[v]) begin
        chk($sformatf("tbl_ch%0d_c%0d", tbl[v].ch, c), int'(clk_en[tbl[v].ch]),
            int'((c >= tbl[v].first) && ((c - tbl[v].first) % tbl[v].period == 0)));
      end
    end

    // Resync with ch0=4, then a mid-period write of 5 and an out-of-range write.
    cfg_we = 1'b1;
    cfg_ch = 4'd0;
    cfg_div = DW'(4);
    resync = 1'b1;
    tick();
    cfg_we = 1'b0;
    resync = 1'b0;
    for (int k = 1; k <= 14; k++) begin
      if (k > 1) tick();
      cfg_we = 1'b0;
      chk($sformatf("div5_ch0_k%0d", k), int'(clk_en[0]), int'(k == 4 || k == 9 || k == 14));
      if (k == 2) begin
        cfg_we = 1'b1; cfg_ch = 4'd0; cfg_div = DW'(5);
      end
      if (k == 6) begin
        cfg_we = 1'b1; cfg_ch = 4'd7; cfg_div = DW'(11);
      end
    end
    cfg_we = 1'b0;

    // Pending ch0=3, then resync with ch1=6 written in the same cycle.
    cfg_write(0, 3);
    cfg_we = 1'b1;
    cfg_ch = 4'd1;
    cfg_div = DW'(6);
    resync = 1'b1;
    tick();
    cfg_we = 1'b0;
    resync = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      if (k > 1) tick();
      chk($sformatf("rs_ch0_k%0d", k), int'(clk_en[0]), int'(k % 3 == 0));
      chk($sformatf("rs_ch1_k%0d", k), int'(clk_en[1]), int'(k % 6 == 0));
      chk($sformatf("rs_ch2_k%0d", k), int'(clk_en[2]), int'(k % 4 == 0));
      chk($sformatf("rs_ch3_k%0d", k), int'(clk_en[3]), 1);
    end

    // Loss of lock in RUN: outputs drop on the third edge.
    lock = 1'b0;
    for (int e = 1; e <= 2; e++) begin
      tick();
      chk("loss_still_locked", int'(locked), 1);
    end
    tick();
    chk("loss_rst_out_n", int'(rst_out_n), 0);
    chk("loss_lost_lock", int'(lost_lock), 1);
    chk("loss_clk_en", int'(clk_en), 0);
    clr_lost = 1'b1;
    tick();
    clr_lost = 1'b0;
    chk("clr_lost_lock", int'(lost_lock), 0);

    // One-cycle glitch while the stability counter reads 10.
    lock = 1'b1;
    for (int e = 1; e <= 11; e++) tick();
    lock = 1'b0;
    tick();
    lock = 1'b1;
    for (int e = 1; e <= 19; e++) begin
      tick();
      chk($sformatf("glitch_locked_e%0d", e), int'(locked), int'(e == 19));
    end

    // Clear and a new loss in the same cycle: set wins.
    lock = 1'b0;
    clr_lost = 1'b1;
    repeat (3) tick();
    clr_lost = 1'b0;
    chk("set_wins_lost_lock", int'(lost_lock), 1);
    chk("set_wins_locked", int'(locked), 0);

    for (int n = 0; n < 1500; n++) begin
      lock = ($urandom_range(0, 199) != 0);
      cfg_we = ($urandom_range(0, 3) == 0);
      cfg_ch = 4'($urandom_range(0, 7));
      cfg_div = DW'($urandom_range(0, 7));
      resync = ($urandom_range(0, 19) == 0);
      clr_lost = ($urandom_range(0, 29) == 0);
      tick();
    end

    // Reset in RUN must not be reported as a loss of lock.
    lock = 1'b1;
    cfg_we = 1'b0;
    resync = 1'b0;
    clr_lost = 1'b1;
    tick();
    clr_lost = 1'b0;
    repeat (24) tick();
    chk("pre_reset_locked", int'(locked), 1);
    reset_n = 1'b0;
    #1;
    chk("midrun_reset_locked", int'(locked), 0);
    chk("midrun_reset_rst_out_n", int'(rst_out_n), 0);
    chk("midrun_reset_clk_en", int'(clk_en), 0);
    lock = 1'b0;
    repeat (3) tick();
    reset_n = 1'b1;
    repeat (5) tick();
    chk("midrun_reset_lost_lock", int'(lost_lock), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
